// File: rtl/occupancy_level_sensor.sv
// Multi-beam doorway sensor. Classifies each pass by the highest beam broken,
// toggles a per-class presence bit when a long-enough pass ends, flags beams
// that stay broken too long, and priority-encodes the tallest occupant class.
module occupancy_level_sensor #(
  parameter int N_LEVELS = 2,
  parameter int MIN_PASS = 2,
  parameter int MAX_PASS = 255,
  parameter int CW       = $clog2(N_LEVELS + 1)
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [N_LEVELS-1:0] G,
  input  logic                CLR_FAULT,
  output logic [N_LEVELS-1:0] PRESENT,
  output logic [CW-1:0]       LEVEL,
  output logic                PASS_STB,
  output logic [CW-1:0]       PASS_CLASS,
  output logic                FAULT,
  output logic [1:0]          dbg_state
);

  localparam int LW = $clog2(MAX_PASS + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PASS  = 2'd1;
  localparam logic [1:0] S_STUCK = 2'd2;

  logic [1:0]          state;
  logic [LW-1:0]       len;
  logic [CW-1:0]       peak;
  logic [CW-1:0]       g_class;
  logic [CW-1:0]       peak_next;
  logic [N_LEVELS-1:0] toggle_mask;
  logic                g_any;

  assign g_any     = |G;
  assign dbg_state = state;

  // Class of the current sample: highest broken beam index + 1, 0 when clear.
  always_comb begin
    g_class = '0;
    for (int i = 0; i < N_LEVELS; i++) begin
      if (G[i]) g_class = CW'(i + 1);
    end
  end

  // Running peak including this sample, and the presence bit the peak selects.
  always_comb begin
    peak_next = (g_class > peak) ? g_class : peak;
    toggle_mask = '0;
    for (int i = 0; i < N_LEVELS; i++) begin
      toggle_mask[i] = (peak == CW'(i + 1));
    end
  end

  // Priority encode of PRESENT: highest class that has someone inside.
  always_comb begin
    LEVEL = '0;
    for (int i = 0; i < N_LEVELS; i++) begin
      if (PRESENT[i]) LEVEL = CW'(i + 1);
    end
  end

  // Pass tracking FSM, presence toggles, strobe and sticky fault.
  // The fault clear is applied before the set so a same-edge set wins.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= S_IDLE;
      len        <= '0;
      peak       <= '0;
      PRESENT    <= '0;
      PASS_STB   <= 1'b0;
      PASS_CLASS <= '0;
      FAULT      <= 1'b0;
    end else begin
      PASS_STB <= 1'b0;
      if (CLR_FAULT && state != S_STUCK) FAULT <= 1'b0;
      case (state)
        S_IDLE: begin
          if (g_any) begin
            state <= S_PASS;
            len   <= LW'(1);
            peak  <= g_class;
          end
        end
        S_PASS: begin
          if (g_any) begin
            if (len == LW'(MAX_PASS)) begin
              // Beam held past the legal pass length: discard the pass.
              state <= S_STUCK;
              len   <= '0;
              peak  <= '0;
              FAULT <= 1'b1;
            end else begin
              len  <= len + LW'(1);
              peak <= peak_next;
            end
          end else begin
            state <= S_IDLE;
            len   <= '0;
            peak  <= '0;
            if (len >= LW'(MIN_PASS)) begin
              PRESENT    <= PRESENT ^ toggle_mask;
              PASS_CLASS <= peak;
              PASS_STB   <= 1'b1;
            end
          end
        end
        S_STUCK: begin
          if (!g_any) state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          len   <= '0;
          peak  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_occupancy_level_sensor.sv
// Bench for occupancy_level_sensor: directed scenarios with literal
// expectations, then randomized passes checked every cycle against a
// run-length based model of the doorway behaviour.
module tb_occupancy_level_sensor;

  localparam int N  = 2;
  localparam int MN = 2;
  localparam int MX = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  g;
  logic          clr;
  logic [N-1:0]  present;
  logic [CW-1:0] level;
  logic          pass_stb;
  logic [CW-1:0] pass_class;
  logic          fault;
  logic [1:0]    dbg_state;

  int n_cmp;
  int n_bad;

  occupancy_level_sensor #(.N_LEVELS(N), .MIN_PASS(MN), .MAX_PASS(MX)) dut (
    .CLK(clk), .RESET(rst_n), .G(g), .CLR_FAULT(clr),
    .PRESENT(present), .LEVEL(level), .PASS_STB(pass_stb),
    .PASS_CLASS(pass_class), .FAULT(fault), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // A pass is just a run of nonzero samples; its length and tallest class
  // decide everything. Runs longer than MX are stuck-beam runs.
  int       run_len;
  int       run_peak;
  bit       m_valid;
  bit [N-1:0] m_present;
  int       m_class;
  bit       m_stb;
  bit       m_fault;

  function automatic int class_of(input logic [N-1:0] v);
    int c;
    c = 0;
    for (int i = 0; i < N; i++) if (v[i]) c = i + 1;
    return c;
  endfunction

  initial begin
    m_valid = 0; run_len = 0; run_peak = 0;
    m_present = '0; m_class = 0; m_stb = 0; m_fault = 0;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      m_valid = 1; run_len = 0; run_peak = 0;
      m_present = '0; m_class = 0; m_stb = 0; m_fault = 0;
    end else if (m_valid) begin
      m_stb = 0;
      if (clr && !(run_len > MX)) m_fault = 0;
      if (g != 0) begin
        run_len++;
        if (class_of(g) > run_peak) run_peak = class_of(g);
        if (run_len == MX + 1) m_fault = 1;
      end else begin
        if (run_len >= MN && run_len <= MX) begin
          m_present[run_peak-1] = ~m_present[run_peak-1];
          m_class = run_peak;
          m_stb = 1;
        end
        run_len = 0;
        run_peak = 0;
      end
    end
  end

  // ---------------- scoreboard / compare ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle, away from the active edge, once reset has defined the model.
  always @(negedge clk) begin
    if (m_valid) begin
      check("present", int'(present), int'(m_present));
      check("level", int'(level), class_of(m_present));
      check("pass_stb", int'(pass_stb), int'(m_stb));
      check("pass_class", int'(pass_class), m_class);
      check("fault", int'(fault), int'(m_fault));
    end
  end

  // ---------------- driver ----------------
  task automatic hold(input logic [N-1:0] gv, input logic c, input logic r, input int n);
    for (int i = 0; i < n; i++) begin
      g = gv; clr = c; rst_n = r;
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    n_cmp = 0; n_bad = 0;
    g = '0; clr = 1'b0; rst_n = 1'b0;

    // Reset
    hold(2'b00, 0, 0, 2);
    check("rst_present", int'(present), 0);
    check("rst_level", int'(level), 0);
    check("rst_stb", int'(pass_stb), 0);
    check("rst_class", int'(pass_class), 0);
    check("rst_fault", int'(fault), 0);

    // Short occupant in, then out
    hold(2'b01, 0, 1, 4); hold(2'b00, 0, 1, 1);
    check("short_in_stb", int'(pass_stb), 1);
    check("short_in_class", int'(pass_class), 1);
    check("short_in_present", int'(present), 1);
    check("short_in_level", int'(level), 1);
    hold(2'b00, 0, 1, 1);
    check("stb_drops", int'(pass_stb), 0);
    hold(2'b01, 0, 1, 4); hold(2'b00, 0, 1, 1);
    check("short_out_present", int'(present), 0);
    check("short_out_level", int'(level), 0);

    // Tall occupant (8 samples, exactly the max), then short, then tall again
    hold(2'b10, 0, 1, 4); hold(2'b01, 0, 1, 4); hold(2'b00, 0, 1, 1);
    check("tall_class", int'(pass_class), 2);
    check("tall_present", int'(present), 2);
    check("tall_level", int'(level), 2);
    hold(2'b01, 0, 1, 4); hold(2'b00, 0, 1, 1);
    check("both_present", int'(present), 3);
    check("both_level", int'(level), 2);
    hold(2'b10, 0, 1, 4); hold(2'b01, 0, 1, 4); hold(2'b00, 0, 1, 1);
    check("tall_out_present", int'(present), 1);
    check("tall_out_level", int'(level), 1);

    // Debounce: 1 sample dropped, exactly MIN accepted
    hold(2'b01, 0, 1, 1); hold(2'b00, 0, 1, 1);
    check("bounce_stb", int'(pass_stb), 0);
    check("bounce_present", int'(present), 1);
    hold(2'b01, 0, 1, 2); hold(2'b00, 0, 1, 1);
    check("min_stb", int'(pass_stb), 1);
    check("min_present", int'(present), 0);

    // Stuck beam
    hold(2'b11, 0, 1, 8);
    check("pre_stuck_fault", int'(fault), 0);
    hold(2'b11, 0, 1, 1);
    check("stuck_fault", int'(fault), 1);
    hold(2'b00, 0, 1, 1);
    check("stuck_end_fault", int'(fault), 1);
    check("stuck_end_stb", int'(pass_stb), 0);
    check("stuck_end_present", int'(present), 0);
    hold(2'b00, 1, 1, 1);
    check("clr_fault", int'(fault), 0);
    hold(2'b01, 0, 1, 8); hold(2'b00, 0, 1, 1);
    check("max_stb", int'(pass_stb), 1);
    check("max_fault", int'(fault), 0);
    check("max_present", int'(present), 1);

    // Reset mid-pass, beam still broken after release
    hold(2'b10, 0, 1, 3);
    hold(2'b10, 0, 0, 1);
    check("midrst_present", int'(present), 0);
    check("midrst_stb", int'(pass_stb), 0);
    hold(2'b10, 0, 1, 1); hold(2'b01, 0, 1, 1); hold(2'b00, 0, 1, 1);
    check("after_rst_stb", int'(pass_stb), 1);
    check("after_rst_class", int'(pass_class), 2);
    check("after_rst_present", int'(present), 2);

    // Randomized passes: lengths straddle MIN and MAX, occasional clears/resets
    for (int p = 0; p < 300; p++) begin
      int len;
      len = $urandom_range(1, MX + 3);
      for (int s = 0; s < len; s++) begin
        hold(2'($urandom_range(1, 3)), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 149) != 0), 1);
      end
      hold(2'b00, ($urandom_range(0, 3) == 0), 1'b1, $urandom_range(1, 3));
    end

    hold(2'b00, 0, 1, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
